bloons_cursor_tracker: RTL and testbench

Cursor and tower-placement stage directly downstream of the `bloonstd1_soc` PIO exports. Consumes the software-written per-frame mouse displacement (`x_displacement_export`, `y_displacement_export`) and the USB `keycode_export`. Produces a clamped on-screen cursor position for the VGA sprite path. Also runs a small tower-select/place request FSM that hands placement events to the game-state logic.

---
 rtl/bloons_cursor_tracker_pkg.sv | 35 +++
 rtl/bloons_cursor_tracker_axis_accumulator.sv | 57 +++++
 rtl/bloons_cursor_tracker.sv | 167 ++++++++++++++++
 tb/tb_bloons_cursor_tracker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bloons_cursor_tracker_pkg.sv
// Shared definitions for the cursor/tower-placement stage.
//   - fsm_state_t : placement FSM states (IDLE / ARMED / REQ)
//   - HID_KEY_*   : USB HID keycodes for tower select, place and cancel
//   - SCREEN_W/H  : default screen geometry feeding the top-level parameters
//   - tower_of_key: maps a keycode to tower number 1..3, or 0 if not a tower key
package bloons_cursor_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REQ   = 2'd2
  } fsm_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [7:0] HID_KEY_1      = 8'h1E;
  localparam logic [7:0] HID_KEY_2      = 8'h1F;
  localparam logic [7:0] HID_KEY_3      = 8'h20;
  localparam logic [7:0] HID_KEY_SPACE  = 8'h2C;
  localparam logic [7:0] HID_KEY_ESCAPE = 8'h29;

  function automatic logic [1:0] tower_of_key(input logic [7:0] key,
                                              input logic [7:0] key_t1,
                                              input logic [7:0] key_t2,
                                              input logic [7:0] key_t3);
    logic [1:0] tower;
    tower = 2'd0;
    if (key == key_t1)      tower = 2'd1;
    else if (key == key_t2) tower = 2'd2;
    else if (key == key_t3) tower = 2'd3;
    return tower;
  endfunction

endpackage

// File: rtl/bloons_cursor_tracker_axis_accumulator.sv
// One cursor axis: on each enabled cycle the 32-bit signed delta is
// saturated to +/-MAX_STEP, added to the current position in signed 12-bit
// arithmetic and clamped to [0, RANGE-1]. Otherwise the position holds.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset (loads RESET_POS)
//   i_en           : frame pulse; applies one delta step
//   i_delta        : signed two's-complement delta
//   o_pos          : registered 10-bit position
module axis_accumulator #(
  parameter int RANGE     = 640,
  parameter int MAX_STEP  = 32,
  parameter int RESET_POS = 320
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [31:0] i_delta,
  output logic [9:0]  o_pos
);

  localparam logic signed [31:0] STEP_HI = MAX_STEP;
  localparam logic signed [31:0] STEP_LO = -MAX_STEP;
  localparam logic signed [11:0] POS_MAX = 12'(RANGE - 1);
  localparam logic [9:0]         POS_RST = 10'(RESET_POS);

  logic [9:0]         r_pos;
  logic signed [31:0] w_delta_s;
  logic signed [11:0] w_step;
  logic signed [11:0] w_sum;
  logic [9:0]         w_pos_next;

  assign w_delta_s = i_delta;

  // Saturating first keeps the sum well inside 12-bit signed range
  // (worst case -MAX_STEP .. RANGE-1+MAX_STEP), so no wrap is possible.
  always_comb begin
    w_step = w_delta_s[11:0];
    if (w_delta_s > STEP_HI)      w_step = STEP_HI[11:0];
    else if (w_delta_s < STEP_LO) w_step = STEP_LO[11:0];
  end

  assign w_sum = $signed({2'b00, r_pos}) + w_step;

  always_comb begin
    w_pos_next = w_sum[9:0];
    if (w_sum < 12'sd0)        w_pos_next = 10'd0;
    else if (w_sum > POS_MAX)  w_pos_next = POS_MAX[9:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_pos <= POS_RST;
    else if (i_en) r_pos <= w_pos_next;
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/bloons_cursor_tracker.sv
// Cursor and tower-placement stage fed by the SoC PIO exports.
//   - Two axis_accumulator instances turn per-frame mouse deltas into a
//     clamped cursor position, updated only on frame_start.
//   - A keycode edge detector produces one event per new non-zero key.
//   - A placement FSM (IDLE/ARMED/REQ) selects a tower and raises place_req
//     with a frozen payload until place_ack.
// Handshake: place_req rises the cycle after a PLACE event and stays high,
// with place_x/place_y/place_tower stable, until the cycle after place_ack
// is sampled high. place_ack outside REQ is ignored.
// Ports:
//   clk_clk, reset_reset_n      : clock, synchronous active-low reset
//   x_displacement/y_displacement: signed per-frame deltas (+y is down)
//   keycode                     : current HID keycode, 0 = none
//   frame_start                 : vsync pulse, applies the deltas once
//   place_ack                   : game logic accepted the placement
//   cursor_x/cursor_y           : cursor position
//   sel_tower                   : selected tower, 0 = none
//   place_req, place_x/y/tower  : placement request and payload
//   fsm_state                   : current FSM state (debug)
module bloons_cursor_tracker
  import bloons_cursor_tracker_pkg::*;
#(
  parameter int         H_RES      = SCREEN_W,
  parameter int         V_RES      = SCREEN_H,
  parameter int         MAX_STEP   = 32,
  parameter logic [7:0] KEY_T1     = HID_KEY_1,
  parameter logic [7:0] KEY_T2     = HID_KEY_2,
  parameter logic [7:0] KEY_T3     = HID_KEY_3,
  parameter logic [7:0] KEY_PLACE  = HID_KEY_SPACE,
  parameter logic [7:0] KEY_CANCEL = HID_KEY_ESCAPE
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] x_displacement,
  input  logic [31:0] y_displacement,
  input  logic [7:0]  keycode,
  input  logic        frame_start,
  input  logic        place_ack,
  output logic [9:0]  cursor_x,
  output logic [9:0]  cursor_y,
  output logic [1:0]  sel_tower,
  output logic        place_req,
  output logic [9:0]  place_x,
  output logic [9:0]  place_y,
  output logic [1:0]  place_tower,
  output logic [1:0]  fsm_state
);

  logic [9:0] w_cursor_x;
  logic [9:0] w_cursor_y;

  axis_accumulator #(
    .RANGE    (H_RES),
    .MAX_STEP (MAX_STEP),
    .RESET_POS(H_RES / 2)
  ) u_axis_x (
    .i_clk  (clk_clk),
    .i_rst_n(reset_reset_n),
    .i_en   (frame_start),
    .i_delta(x_displacement),
    .o_pos  (w_cursor_x)
  );

  axis_accumulator #(
    .RANGE    (V_RES),
    .MAX_STEP (MAX_STEP),
    .RESET_POS(V_RES / 2)
  ) u_axis_y (
    .i_clk  (clk_clk),
    .i_rst_n(reset_reset_n),
    .i_en   (frame_start),
    .i_delta(y_displacement),
    .o_pos  (w_cursor_y)
  );

  // Key edge detector: a held key produces exactly one event.
  logic [7:0] r_prev_key;
  logic       w_key_evt;
  logic [1:0] w_key_tower;

  assign w_key_evt   = (keycode != r_prev_key) && (keycode != 8'd0);
  assign w_key_tower = tower_of_key(keycode, KEY_T1, KEY_T2, KEY_T3);

  fsm_state_t r_state, w_state_next;
  logic [1:0] r_sel, w_sel_next;
  logic       r_req, w_req_next;
  logic [9:0] r_px, w_px_next;
  logic [9:0] r_py, w_py_next;
  logic [1:0] r_pt, w_pt_next;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state    <= ST_IDLE;
      r_prev_key <= 8'd0;
      r_sel      <= 2'd0;
      r_req      <= 1'b0;
      r_px       <= 10'd0;
      r_py       <= 10'd0;
      r_pt       <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_prev_key <= keycode;
      r_sel      <= w_sel_next;
      r_req      <= w_req_next;
      r_px       <= w_px_next;
      r_py       <= w_py_next;
      r_pt       <= w_pt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_req_next   = r_req;
    w_px_next    = r_px;
    w_py_next    = r_py;
    w_pt_next    = r_pt;
    case (r_state)
      ST_IDLE: begin
        if (w_key_evt && (w_key_tower != 2'd0)) begin
          w_sel_next   = w_key_tower;
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_key_evt) begin
          if (w_key_tower != 2'd0) begin
            w_sel_next = w_key_tower;
          end else if (keycode == KEY_CANCEL) begin
            w_sel_next   = 2'd0;
            w_state_next = ST_IDLE;
          end else if (keycode == KEY_PLACE) begin
            // Payload takes the registered cursor, i.e. the position before
            // any frame update happening in this same cycle.
            w_px_next    = w_cursor_x;
            w_py_next    = w_cursor_y;
            w_pt_next    = r_sel;
            w_req_next   = 1'b1;
            w_state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (place_ack) begin
          w_req_next   = 1'b0;
          w_sel_next   = 2'd0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_sel_next   = 2'd0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign cursor_x    = w_cursor_x;
  assign cursor_y    = w_cursor_y;
  assign sel_tower   = r_sel;
  assign place_req   = r_req;
  assign place_x     = r_px;
  assign place_y     = r_py;
  assign place_tower = r_pt;
  assign fsm_state   = r_state;

endmodule

// File: tb/tb_bloons_cursor_tracker.sv
module tb_bloons_cursor_tracker;
  import bloons_cursor_tracker_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [31:0] x_displacement;
  logic [31:0] y_displacement;
  logic [7:0]  keycode;
  logic        frame_start;
  logic        place_ack;
  logic [9:0]  cursor_x, cursor_y, place_x, place_y;
  logic [1:0]  sel_tower, place_tower, fsm_state;
  logic        place_req;

  always #5 clk_clk = ~clk_clk;

  bloons_cursor_tracker dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .x_displacement(x_displacement),
    .y_displacement(y_displacement),
    .keycode       (keycode),
    .frame_start   (frame_start),
    .place_ack     (place_ack),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .sel_tower     (sel_tower),
    .place_req     (place_req),
    .place_x       (place_x),
    .place_y       (place_y),
    .place_tower   (place_tower),
    .fsm_state     (fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_x, m_y, m_sel, m_px, m_py, m_pt;
  bit         m_req;
  fsm_state_t m_state;
  int         m_prev;

  function automatic int move_axis(input int pos, input logic [31:0] d, input int range);
    int s;
    s = $signed(d);
    if (s > 32)  s = 32;
    if (s < -32) s = -32;
    pos = pos + s;
    if (pos < 0)         pos = 0;
    if (pos > range - 1) pos = range - 1;
    return pos;
  endfunction

  function automatic int tower_num(input int k);
    if (k == 'h1E) return 1;
    if (k == 'h1F) return 2;
    if (k == 'h20) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240; m_sel = 0; m_req = 0;
    m_px = 0; m_py = 0; m_pt = 0; m_state = ST_IDLE; m_prev = 0;
  endtask

  task automatic model_clock();
    int  k;
    bit  evt;
    int  old_x, old_y;
    k = int'(keycode);
    evt = (k != m_prev) && (k != 0);
    old_x = m_x; old_y = m_y;
    if (frame_start) begin
      m_x = move_axis(m_x, x_displacement, 640);
      m_y = move_axis(m_y, y_displacement, 480);
    end
    if (m_state == ST_IDLE) begin
      if (evt && tower_num(k) != 0) begin m_sel = tower_num(k); m_state = ST_ARMED; end
    end else if (m_state == ST_ARMED) begin
      if (evt && tower_num(k) != 0) m_sel = tower_num(k);
      else if (evt && k == 'h29) begin m_sel = 0; m_state = ST_IDLE; end
      else if (evt && k == 'h2C) begin
        m_px = old_x; m_py = old_y; m_pt = m_sel; m_req = 1; m_state = ST_REQ;
      end
    end else begin
      if (place_ack) begin m_req = 0; m_sel = 0; m_state = ST_IDLE; end
    end
    m_prev = k;
  endtask

  task automatic check_all();
    chk("cursor_x", int'(cursor_x), m_x);
    chk("cursor_y", int'(cursor_y), m_y);
    chk("sel_tower", int'(sel_tower), m_sel);
    chk("place_req", int'(place_req), int'(m_req));
    chk("place_x", int'(place_x), m_px);
    chk("place_y", int'(place_y), m_py);
    chk("place_tower", int'(place_tower), m_pt);
    chk("fsm_state", int'(fsm_state), int'(m_state));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic fs, input logic [31:0] xd, input logic [31:0] yd,
                      input logic [7:0] key, input logic ack);
    frame_start = fs; x_displacement = xd; y_displacement = yd;
    keycode = key; place_ack = ack;
    model_clock();
    @(posedge clk_clk);
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic [7:0] key);
    reset_reset_n = 1'b0;
    frame_start = 1'b0; place_ack = 1'b0; keycode = key;
    model_reset();
    @(posedge clk_clk);
    #1;
    check_all();
    reset_reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       fs;
    logic [31:0] xd;
    logic [31:0] yd;
    logic [7:0] key;
    logic       ack;
    int         ex;
    int         ey;
    int         esel;
    int         ereq;
    fsm_state_t est;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 32'd5,    32'hFFFF_FFFD, 8'h00, 1'b0, 325, 237, 0, 0, ST_IDLE};
    tbl[1]  = '{1'b0, 32'd5,    32'hFFFF_FFFD, 8'h00, 1'b0, 325, 237, 0, 0, ST_IDLE};
    tbl[2]  = '{1'b1, 32'd5,    32'hFFFF_FFFD, 8'h00, 1'b0, 330, 234, 0, 0, ST_IDLE};
    tbl[3]  = '{1'b1, 32'd5,    32'hFFFF_FFFD, 8'h00, 1'b0, 335, 231, 0, 0, ST_IDLE};
    tbl[4]  = '{1'b1, 32'd1000, 32'd0,         8'h00, 1'b0, 367, 231, 0, 0, ST_IDLE};
    tbl[5]  = '{1'b0, -32'sd1000, 32'd0,       8'h00, 1'b1, 367, 231, 0, 0, ST_IDLE};
    tbl[6]  = '{1'b0, 32'd0,    32'd0,         8'h1E, 1'b0, 367, 231, 1, 0, ST_ARMED};
    tbl[7]  = '{1'b0, 32'd0,    32'd0,         8'h1E, 1'b0, 367, 231, 1, 0, ST_ARMED};
    tbl[8]  = '{1'b0, 32'd0,    32'd0,         8'h1F, 1'b0, 367, 231, 2, 0, ST_ARMED};
    tbl[9]  = '{1'b0, 32'd0,    32'd0,         8'h00, 1'b0, 367, 231, 2, 0, ST_ARMED};
    tbl[10] = '{1'b0, 32'd0,    32'd0,         8'h29, 1'b0, 367, 231, 0, 0, ST_IDLE};
    tbl[11] = '{1'b0, 32'd0,    32'd0,         8'h2C, 1'b0, 367, 231, 0, 0, ST_IDLE};
  end

  // ---------------- main test ----------------
  initial begin
    reset_reset_n = 1'b0; frame_start = 1'b0; place_ack = 1'b0;
    keycode = 8'h00; x_displacement = 32'd0; y_displacement = 32'd0;
    #2;
    do_reset(8'h00);

    // Table-driven: cursor motion, saturation, key select/cancel, idle place
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].fs, tbl[i].xd, tbl[i].yd, tbl[i].key, tbl[i].ack);
      chk($sformatf("tbl%0d_x", i), int'(cursor_x), tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), int'(cursor_y), tbl[i].ey);
      chk($sformatf("tbl%0d_sel", i), int'(sel_tower), tbl[i].esel);
      chk($sformatf("tbl%0d_req", i), int'(place_req), tbl[i].ereq);
      chk($sformatf("tbl%0d_state", i), int'(fsm_state), int'(tbl[i].est));
    end

    // Left clamp without wrap, then bottom clamp
    for (int i = 0; i < 20; i++) step(1'b1, -32'sd1000, 32'd0, 8'h00, 1'b0);
    chk("clamp_x_low", int'(cursor_x), 0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'd0, 32'd40000, 8'h00, 1'b0);
    chk("clamp_y_high", int'(cursor_y), 479);

    // Held key: one event only; then a new tower key
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd0, 32'd0, 8'h1E, 1'b0);
      chk("hold_sel", int'(sel_tower), 1);
      chk("hold_state", int'(fsm_state), int'(ST_ARMED));
    end
    step(1'b0, 32'd0, 32'd0, 8'h1F, 1'b0);
    chk("reselect_sel", int'(sel_tower), 2);
    chk("reselect_state", int'(fsm_state), int'(ST_ARMED));

    // Move to (100,200), arm tower 3, place together with a frame update
    do_reset(8'h00);
    step(1'b1, -32'sd32, -32'sd32, 8'h00, 1'b0);
    step(1'b1, -32'sd32, -32'sd8,  8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, -32'sd32, 32'd0, 8'h00, 1'b0);
    step(1'b1, -32'sd28, 32'd0, 8'h00, 1'b0);
    chk("pre_place_x", int'(cursor_x), 100);
    chk("pre_place_y", int'(cursor_y), 200);
    step(1'b0, 32'd0, 32'd0, 8'h20, 1'b0);
    chk("arm3_sel", int'(sel_tower), 3);
    step(1'b1, 32'd5, 32'd5, 8'h2C, 1'b0);
    chk("place_req_up", int'(place_req), 1);
    chk("place_x_val", int'(place_x), 100);
    chk("place_y_val", int'(place_y), 200);
    chk("place_tower_val", int'(place_tower), 3);
    chk("cursor_after_x", int'(cursor_x), 105);
    chk("cursor_after_y", int'(cursor_y), 205);

    // REQ ignores keys while waiting for ack
    for (int i = 0; i < 50; i++) step(1'b0, 32'd0, 32'd0, (i % 2 == 0) ? 8'h1E : 8'h29, 1'b0);
    chk("req_hold", int'(place_req), 1);
    chk("req_hold_px", int'(place_x), 100);
    chk("req_hold_tower", int'(place_tower), 3);
    step(1'b0, 32'd0, 32'd0, 8'h00, 1'b1);
    chk("ack_req_low", int'(place_req), 0);
    chk("ack_sel_zero", int'(sel_tower), 0);
    chk("ack_state", int'(fsm_state), int'(ST_IDLE));
    step(1'b0, 32'd0, 32'd0, 8'h00, 1'b1);

    // Minimum turnaround: PLACE, ack next cycle
    step(1'b0, 32'd0, 32'd0, 8'h1F, 1'b0);
    step(1'b0, 32'd0, 32'd0, 8'h2C, 1'b0);
    chk("turn_req", int'(place_req), 1);
    step(1'b0, 32'd0, 32'd0, 8'h2C, 1'b1);
    chk("turn_req_low", int'(place_req), 0);

    // Reset while in REQ
    step(1'b0, 32'd0, 32'd0, 8'h20, 1'b0);
    step(1'b1, 32'd7, 32'd7, 8'h2C, 1'b0);
    chk("req_before_rst", int'(place_req), 1);
    do_reset(8'h2C);
    chk("rst_req", int'(place_req), 0);
    chk("rst_state", int'(fsm_state), int'(ST_IDLE));
    chk("rst_x", int'(cursor_x), 320);
    chk("rst_y", int'(cursor_y), 240);

    // Randomised stimulus against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] xd, yd;
      logic [7:0]  k;
      int          sel;
      xd = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 100)) - 50);
      yd = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 100)) - 50);
      sel = $urandom_range(0, 7);
      case (sel)
        0: k = 8'h1E; 1: k = 8'h1F; 2: k = 8'h20; 3: k = 8'h2C;
        4: k = 8'h29; 5: k = 8'h04; default: k = 8'h00;
      endcase
      step(($urandom_range(0, 3) == 0), xd, yd, k, ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
